// File: rtl/dmem_responder_pkg.sv
// Shared constants and state encoding for the data-memory responder.
package dmem_responder_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned STRB_W      = 4;
   localparam int unsigned MAX_LATENCY = 15;
   localparam int unsigned CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage with byte-enable writes and a registered read port.
module dmem_bank
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Byte-lane write and registered read, both on the commit edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (rd_en) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable access latency and
// misaligned / out-of-range error reporting.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dmem_state_e       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              accept;
   logic              commit;

   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   logic              c_we;
   logic [31:0]       c_addr;
   logic [31:0]       c_wdata;
   logic [3:0]        c_wstrb;
   logic [31:0]       offset;
   logic              c_err;

   logic              err_q;
   logic              load_ok_q;
   logic [31:0]       bank_rdata;

   assign accept = req_valid & req_ready;

   // With LATENCY == 1 the commit edge is the accept edge, so the live
   // request is used there; otherwise the latched copy is used.
   assign c_we    = (state == IDLE) ? req_we    : we_q;
   assign c_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign c_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign c_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

   assign offset = c_addr - BASE_ADDR;
   assign c_err  = (offset[1:0] != 2'b00) | (c_addr < BASE_ADDR)
                 | ({2'b00, offset[31:2]} >= 32'(DEPTH));

   // Next-state, latency countdown and handshake outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = ~rst;
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter and response-status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         err_q     <= 1'b0;
         load_ok_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (commit) begin
            err_q     <= c_err;
            load_ok_q <= ~c_we & ~c_err;
         end
      end
   end

   // Request capture on the accept edge only.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   dmem_bank #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk   (clk),
      .wr_en (commit & ~rst & c_we & ~c_err),
      .rd_en (commit & ~rst & ~c_we & ~c_err),
      .idx   (offset[IDX_W+1:2]),
      .wdata (c_wdata),
      .wstrb (c_wstrb),
      .rdata (bank_rdata)
   );

   assign rsp_rdata = load_ok_q ? bank_rdata : '0;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 2 and 4),
// directed stimulus with hand-computed expectations.
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_rdata [2];
   logic [1:0]  rsp_err;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(
      .DEPTH     (64),
      .LATENCY   (2),
      .BASE_ADDR (32'h0000_0000)
   ) dut0 (
      .clk       (clk),
      .rst       (rst[0]),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .req_wstrb (req_wstrb[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata[0]),
      .rsp_err   (rsp_err[0])
   );

   dmem_responder #(
      .DEPTH     (16),
      .LATENCY   (4),
      .BASE_ADDR (32'h0000_0000)
   ) dut1 (
      .clk       (clk),
      .rst       (rst[1]),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .req_wstrb (req_wstrb[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata[1]),
      .rsp_err   (rsp_err[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t pop(input int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Per-instance monitor: checks every response handshake against the
   // scoreboard, plus hold-stability and req_ready while stalled.
   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int LAT = (g == 0) ? 2 : 4;
      int          first_cyc = -1;
      logic        prev_valid = 1'b0;
      logic [31:0] prev_rdata;
      logic        prev_err;
      exp_t        e;

      always @(negedge clk) begin
         if (rst[g]) begin
            first_cyc  = -1;
            prev_valid = 1'b0;
         end else if (rsp_valid[g]) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (prev_valid) begin
               chk("hold_rdata", rsp_rdata[g], prev_rdata);
               chk("hold_err", rsp_err[g], prev_err);
            end
            chk("req_ready_in_resp", req_ready[g], 0);
            if (rsp_ready[g]) begin
               if (qsize(g) == 0) begin
                  fail_now("unexpected_rsp");
               end else begin
                  e = pop(g);
                  chk("rsp_rdata", rsp_rdata[g], e.rdata);
                  chk("rsp_err", rsp_err[g], e.err);
                  chk("latency", first_cyc - e.acc, LAT);
               end
               first_cyc  = -1;
               prev_valid = 1'b0;
            end else begin
               prev_valid = 1'b1;
               prev_rdata = rsp_rdata[g];
               prev_err   = rsp_err[g];
            end
         end else begin
            prev_valid = 1'b0;
         end
      end
   end

   task automatic issue(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] er, input logic ee, input bit track);
      int   n;
      exp_t e;
      @(posedge clk); #1;
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wstrb[d] = strb;
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready[d]) begin
         chk("accept_timeout", req_ready[d], 1);
      end else if (track) begin
         e.rdata = er;
         e.err   = ee;
         e.acc   = cyc;
         push(d, e);
      end
      @(posedge clk); #1;
      // Scramble request inputs to show they are ignored after accept.
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_addr[d]  = 32'hFFFF_FFF1;
      req_wdata[d] = ~wdata;
      req_wstrb[d] = 4'hF;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (qsize(d) != 0) begin
         chk("rsp_timeout", qsize(d), 0);
         if (d == 0) q0.delete();
         else q1.delete();
      end
   endtask

   task automatic acc(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] er, input logic ee);
      issue(d, we, addr, wdata, strb, er, ee, 1'b1);
      wait_done(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst       = 2'b11;
      req_valid = 2'b00;
      req_we    = 2'b00;
      rsp_ready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_wstrb[i] = '0;
      end

      // Reset: two cycles held high.
      @(negedge clk);
      chk("rst_req_ready0", req_ready[0], 0);
      chk("rst_req_ready1", req_ready[1], 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 2'b00;
      @(negedge clk);
      chk("post_rst_req_ready0", req_ready[0], 1);
      chk("post_rst_req_ready1", req_ready[1], 1);
      chk("post_rst_rsp_valid0", rsp_valid[0], 0);
      chk("post_rst_rsp_rdata0", rsp_rdata[0], 32'h0);
      chk("post_rst_rsp_err0", rsp_err[0], 0);
      chk("post_rst_rsp_valid1", rsp_valid[1], 0);

      // Store then load, full word.
      acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      // Partial store of lane 0.
      acc(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
      // Zero-strobe store is a no-op without error.
      acc(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, 32'h0, 1'b0);
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
      // Misaligned load.
      acc(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
      // Out-of-range store leaves the last word alone.
      acc(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      acc(0, 1'b1, 32'h100, 32'h0BADF00D, 4'hF, 32'h0, 1'b1);
      acc(0, 1'b0, 32'hFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
      acc(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
      // Misaligned store does not modify the word; top-lane partial store.
      acc(0, 1'b1, 32'h40, 32'h11112222, 4'hF, 32'h0, 1'b0);
      acc(0, 1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
      acc(0, 1'b1, 32'h40, 32'h77000000, 4'b1000, 32'h0, 1'b0);
      acc(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h77112222, 1'b0);

      // Backpressure: stall the response five cycles, pulse a stray request.
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1);
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid_seen", rsp_valid[0], 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'h40;
            req_wdata[0] = 32'hBAD0BAD0;
            req_wstrb[0] = 4'hF;
         end
         if (i == 2) req_valid[0] = 1'b0;
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid[0], 1);
         chk("bp_req_ready", req_ready[0], 0);
      end
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      wait_done(0);
      acc(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h77112222, 1'b0);

      // LATENCY 4 instance: seed, then reset while a store is in WAIT.
      acc(1, 1'b1, 32'h20, 32'h00000000, 4'hF, 32'h0, 1'b0);
      acc(1, 1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
      acc(1, 1'b0, 32'h24, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
      issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0);
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_wait_rst_no_valid", rsp_valid[1], 0);
      end
      acc(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h00000000, 1'b0);
      acc(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);

      repeat (4) @(posedge clk);
      chk("sb_empty0", q0.size(), 0);
      chk("sb_empty1", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for data accesses issued by the pipeline's MEM stage over a valid/ready request/response interface.
- Contains a word-organised data array with byte-strobe writes and configurable access latency.
- Flags misaligned and out-of-range accesses.
- Sits between the core's load/store path and the data storage, replacing the single-cycle data memory when a stalling memory model is needed.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  clock, all logic on the rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, lane i = bits 8i+7:8i
- req_wstrb  input  4  byte-lane write enables
- rsp_valid  output  1  response available
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  access was misaligned or out of range

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset values: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- req_ready is 0 while rst is high. Array contents are not reset.
- States:
  - IDLE: req_ready = 1, rsp_valid = 0.
    - On req_valid & req_ready, latch we/addr/wdata/wstrb.
    - If LATENCY == 1, go to RESP. Otherwise go to WAIT with cnt = LATENCY-1.
  - WAIT: req_ready = 0.
    - If cnt == 1, go to RESP. Otherwise cnt <= cnt-1.
  - RESP: rsp_valid = 1, req_ready = 0.
    - rsp_rdata and rsp_err are held stable until rsp_ready.
    - On rsp_valid & rsp_ready, go to IDLE.
- Latency:
  - A request accepted at edge t gives rsp_valid high from cycle t+LATENCY.
  - Throughput is at most one access per LATENCY+1 cycles. No new request is accepted in the response-handshake cycle.
- Commit point:
  - The array read or write happens on the edge that enters RESP.
  - A load latches array[idx] into rsp_rdata.
  - A store writes byte lane i iff wstrb[i]. rsp_rdata is set to 0.
  - A store with wstrb = 0 is a legal no-op with err = 0.
- Address: idx = (req_addr - BASE_ADDR) >> 2, computed on the latched address.
- Errors:
  - An error is raised if addr[1:0] != 0, if addr < BASE_ADDR, or if idx >= DEPTH.
  - On error: rsp_err = 1, rsp_rdata = 0, and the array is not modified.
  - The response still completes through the normal handshake.
- Request inputs are ignored except at the accept edge. Changing them in WAIT or RESP has no effect.
- rsp_ready asserted outside RESP has no effect.
- Reset mid-operation (WAIT or RESP):
  - The responder returns to IDLE next cycle and the response is dropped.
  - A store still in WAIT is never committed. A store already in RESP has already been committed.
- A load of a never-written word returns X. The bench must write a word before reading it.

Decomposition:
- const.svh holds:
  - DMEM state encodings IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Word width 32 and strobe width 4.
  - Maximum latency constant 15, which sets the counter width to 4.
- Sub-module dmem_bank:
  - DEPTH x 32 storage with byte-enable synchronous write.
  - Registered read port driven by a single enable from the FSM.
  - dmem_responder keeps the FSM, latency counter, address check and response registers.

Test Plan:
- Reset: hold rst 2 cycles -> req_ready = 0 during reset, then 1; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Store then load, LATENCY = 2:
  - Store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> rsp_valid exactly 2 cycles after accept, rdata = 0, err = 0.
  - Load 0x10 -> rdata = 0xDEADBEEF.
- Partial store: store 0x10, wdata 0x000000AA, wstrb 4'b0001 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
- Errors:
  - Load 0x13 -> err = 1, rdata = 0.
  - Store to 4*DEPTH -> err = 1; a load of word DEPTH-1 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata and err stable; req_ready = 0 throughout; a req_valid pulse is ignored.
- Reset mid-WAIT with LATENCY = 4:
  - Store 0x20, 0x12345678, assert rst one cycle after accept -> no rsp_valid.
  - A following load of 0x20 returns the previously written value 0x00000000.
